// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C responder and bus front end: byte width,
// ACK/NACK bus levels, transmit fill byte and the responder state encoding.
package i2c_pkg;

    localparam int BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Byte returned on a read when no transmit data is available
    localparam logic [BYTE_W-1:0] TX_FILL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with single-cycle edge, START and STOP pulses.
// Shared between the I2C target and controller front ends.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i2c_clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // NOTE: the chain resets to the idle-bus level (high) so leaving reset never fakes an edge or START.
    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: ACKs SLAVE_ADDR, streams write bytes out on rx_*, read bytes in on tx_*.
// Optional clock stretching on an empty transmit source: I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              i2c_clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              rw_dir
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .i2c_clk    (i2c_clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_e            r_state;
    logic [BYTE_W-1:0] r_shift;
    logic [2:0]        r_cnt;
    logic              r_sda_oe;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_load;
    logic              r_rx_valid;
    logic              r_tx_ready;
    logic              r_busy;
    logic              r_rw_dir;
    logic              r_ack_rcvd;
    logic [BYTE_W-1:0] w_byte;
    logic              w_load_pt;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic              r_scl_oe;
    logic              r_stretch;
    logic [1:0]        r_rel_cnt;
`else
    logic [BYTE_W-1:0] w_tx_byte;
    assign w_tx_byte = tx_valid ? tx_data : TX_FILL;
`endif

    assign w_byte = {r_shift[BYTE_W-2:0], w_sda};

    // Transmit load points: end of the address ACK on a read, and the fall after a master ACK
    assign w_load_pt = w_scl_fall &&
                       ((r_state == ST_ADDR_ACK && r_sda_oe && r_rw_dir) ||
                        (r_state == ST_TX_ACK && r_ack_rcvd));

    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= 3'd7;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_load  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_rw_dir   <= 1'b0;
            r_ack_rcvd <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            r_scl_oe   <= 1'b0;
            r_stretch  <= 1'b0;
            r_rel_cnt  <= 2'd0;
`endif
        end else begin
            r_rx_load  <= 1'b0;
            r_rx_valid <= r_rx_load;
            r_tx_ready <= 1'b0;

            if (w_stop || w_start) begin
                r_state    <= w_stop ? ST_IDLE : ST_ADDR;
                r_cnt      <= 3'd7;
                r_sda_oe   <= 1'b0;
                r_ack_rcvd <= 1'b0;
                if (w_stop)
                    r_busy <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                r_scl_oe   <= 1'b0;
                r_stretch  <= 1'b0;
                r_rel_cnt  <= 2'd0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_cnt == 3'd0) begin
                                r_cnt <= 3'd7;
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_state  <= ST_ADDR_ACK;
                                    r_rw_dir <= w_byte[0];
                                    r_busy   <= 1'b1;
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end

                    // First fall pulls SDA low for the ACK clock, second fall ends it
                    ST_ADDR_ACK, ST_RX_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= 3'd7;
                                if (r_state == ST_ADDR_ACK && r_rw_dir)
                                    r_state <= ST_TX_DATA;
                                else
                                    r_state <= ST_RX_DATA;
                            end
                        end
                    end

                    ST_RX_DATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_cnt == 3'd0) begin
                                r_rx_data <= w_byte;
                                r_rx_load <= 1'b1;
                                r_cnt     <= 3'd7;
                                r_state   <= ST_RX_ACK;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end

                    ST_TX_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        if (w_scl_fall && !r_stretch) begin
`else
                        if (w_scl_fall) begin
`endif
                            if (r_cnt == 3'd0) begin
                                r_sda_oe   <= 1'b0;
                                r_ack_rcvd <= 1'b0;
                                r_state    <= ST_TX_ACK;
                            end else begin
                                // Rotate rather than zero-fill; the vacated bits are never sent
                                r_shift  <= {r_shift[BYTE_W-2:0], r_shift[BYTE_W-1]};
                                r_sda_oe <= ~r_shift[BYTE_W-2];
                                r_cnt    <= r_cnt - 3'd1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (w_scl_rise && !r_ack_rcvd) begin
                            if (w_sda == I2C_NACK)
                                r_state <= ST_WAIT_STOP;
                            else
                                r_ack_rcvd <= 1'b1;
                        end
                    end

                    ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase

                if (w_load_pt) begin
                    r_state    <= ST_TX_DATA;
                    r_cnt      <= 3'd7;
                    r_ack_rcvd <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    if (tx_valid) begin
                        r_shift    <= tx_data;
                        r_sda_oe   <= ~tx_data[BYTE_W-1];
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_sda_oe  <= 1'b0;
                        r_scl_oe  <= 1'b1;
                        r_stretch <= 1'b1;
                        r_rel_cnt <= 2'd0;
                    end
`else
                    r_shift    <= w_tx_byte;
                    r_sda_oe   <= ~w_tx_byte[BYTE_W-1];
                    r_tx_ready <= tx_valid;
`endif
                end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
                // While SCL is held: load once data appears, then keep SCL low two more cycles for SDA setup
                if (r_stretch) begin
                    if (r_rel_cnt == 2'd0) begin
                        if (tx_valid) begin
                            r_shift    <= tx_data;
                            r_sda_oe   <= ~tx_data[BYTE_W-1];
                            r_tx_ready <= 1'b1;
                            r_rel_cnt  <= 2'd2;
                        end
                    end else if (r_rel_cnt == 2'd1) begin
                        r_scl_oe  <= 1'b0;
                        r_stretch <= 1'b0;
                        r_rel_cnt <= 2'd0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - 2'd1;
                    end
                end
`endif
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign rw_dir   = r_rw_dir;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign scl_oe   = r_scl_oe;
`else
    assign scl_oe   = 1'b0;
`endif

endmodule
